clk_sw_ctrl: RTL and testbench

Sequencer for a glitch-free system clock switch. It owns the select input of the clock mux cell and the enable input of the clock gate cell that follows the mux. On a switch request it gates the clock off, waits, flips the mux select, waits for the mux to settle, then re-enables the gate and reports completion. It runs on an always-on reference clock and sits between the PMU/clock-control registers and the clock mux + gate cells.

---
 rtl/clk_sw_ctrl.sv | 145 ++++++++++++++
 tb/tb_clk_sw_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_sw_ctrl.sv
// clk_sw_ctrl: sequencer for a glitch-free clock switch.
// It gates the clock off, holds it gated for GATE_OFF_CYC cycles, flips the
// mux select, waits SEL_SETTLE_CYC cycles for the mux to settle, then
// re-enables the gate and pulses sw_done. Every output is a flop, so the
// mux/gate cells never see a combinational path from the request inputs.
module clk_sw_ctrl #(
   parameter int GATE_OFF_CYC   = 4,
   parameter int SEL_SETTLE_CYC = 8,
   parameter int CNT_W          = 4
) (
   input  logic clk,
   input  logic rst_b,
   input  logic sw_req,
   input  logic sw_target,
   output logic clk_mux_sel,
   output logic clk_gate_en,
   output logic sw_busy,
   output logic sw_done
);

   // Counter reload values: a phase of N cycles counts N-1 down to 0.
   localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_OFF_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SEL_SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GATE_OFF = 2'd1,
      ST_SETTLE   = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_tgt;
   logic             r_sel;
   logic             r_gate;
   logic             r_busy;
   logic             r_done;

   state_t           w_state;
   logic [CNT_W-1:0] w_cnt;
   logic             w_tgt;
   logic             w_sel;
   logic             w_gate;
   logic             w_busy;
   logic             w_done;
   logic             w_cnt_zero;

   assign w_cnt_zero = (r_cnt == CNT_ZERO);

   // Next-state and next-output logic; every next value defaults to "hold",
   // and sw_done defaults low so it can only ever be a single-cycle pulse.
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_tgt   = r_tgt;
      w_sel   = r_sel;
      w_gate  = r_gate;
      w_busy  = r_busy;
      w_done  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (sw_req) begin
               if (sw_target != r_sel) begin
                  // Real switch: gate first, select changes later.
                  w_tgt   = sw_target;
                  w_gate  = 1'b0;
                  w_busy  = 1'b1;
                  w_cnt   = GATE_LOAD;
                  w_state = ST_GATE_OFF;
               end else begin
                  // Already on the requested source: acknowledge only.
                  w_done = 1'b1;
               end
            end else begin
               w_done = 1'b0;
            end
         end

         ST_GATE_OFF: begin
            if (w_cnt_zero) begin
               // Gate has been off long enough; select may now change.
               w_sel   = r_tgt;
               w_cnt   = SETTLE_LOAD;
               w_state = ST_SETTLE;
            end else begin
               w_cnt = r_cnt - CNT_ONE;
            end
         end

         ST_SETTLE: begin
            if (w_cnt_zero) begin
               // Select is stable; the gate never opens in the cycle the
               // select moved because this state lasts at least one cycle.
               w_gate  = 1'b1;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_state = ST_IDLE;
            end else begin
               w_cnt = r_cnt - CNT_ONE;
            end
         end

         default: begin
            // Illegal encoding: fall back to a running clock in IDLE with the
            // select untouched, so no glitch is produced on recovery.
            w_state = ST_IDLE;
            w_cnt   = CNT_ZERO;
            w_gate  = 1'b1;
            w_busy  = 1'b0;
            w_done  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset; reset
   // forces the clock running on source D0 and drops any request in flight.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_state <= ST_IDLE;
         r_cnt   <= CNT_ZERO;
         r_tgt   <= 1'b0;
         r_sel   <= 1'b0;
         r_gate  <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_tgt   <= w_tgt;
         r_sel   <= w_sel;
         r_gate  <= w_gate;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   assign clk_mux_sel = r_sel;
   assign clk_gate_en = r_gate;
   assign sw_busy     = r_busy;
   assign sw_done     = r_done;

endmodule

// File: tb/tb_clk_sw_ctrl.sv
// Bench for clk_sw_ctrl: default-parameter instance plus a 1/1/1 corner
// instance. Expected sw_done events are queued at request time and checked
// by independent monitors; a per-edge monitor enforces the gating invariant.
module tb_clk_sw_ctrl;

   typedef struct packed {
      logic sel;
      int   cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_b, req, tgt, sel, gate, busy, done;
   logic c_req, c_tgt, c_sel, c_gate, c_busy, c_done;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];

   clk_sw_ctrl dut (
      .clk(clk), .rst_b(rst_b), .sw_req(req), .sw_target(tgt),
      .clk_mux_sel(sel), .clk_gate_en(gate), .sw_busy(busy), .sw_done(done)
   );

   clk_sw_ctrl #(.GATE_OFF_CYC(1), .SEL_SETTLE_CYC(1), .CNT_W(1)) dut_c (
      .clk(clk), .rst_b(rst_b), .sw_req(c_req), .sw_target(c_tgt),
      .clk_mux_sel(c_sel), .clk_gate_en(c_gate), .sw_busy(c_busy), .sw_done(c_done)
   );

   // Edge counter: at the negedge after posedge k, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Issue a one-cycle request to instance d; sampled at edge e0 = cyc+1.
   task automatic issue(input int d, input logic t, input int lat, input bit expect_done,
                        output int e0);
      exp_t e;
      e0 = cyc + 1;
      e.sel = t;
      e.cyc = e0 + lat;
      if (d == 0) begin
         req = 1'b1; tgt = t;
         if (expect_done) q0.push_back(e);
      end else begin
         c_req = 1'b1; c_tgt = t;
         if (expect_done) q1.push_back(e);
      end
      @(negedge clk);
      if (d == 0) req = 1'b0;
      else c_req = 1'b0;
   endtask

   // Scoreboard monitor for the default instance.
   always @(negedge clk) begin : mon0
      exp_t e;
      if (done === 1'b1) begin
         if (q0.size() == 0) begin
            chk("dut0 unexpected sw_done", 32'd1, 32'd0);
         end else begin
            e = q0.pop_front();
            chk("dut0 done cycle", cyc, e.cyc);
            chk("dut0 done sel", {31'd0, sel}, {31'd0, e.sel});
            chk("dut0 done gate", {31'd0, gate}, 32'd1);
            chk("dut0 done busy", {31'd0, busy}, 32'd0);
         end
      end
   end

   // Scoreboard monitor for the corner instance.
   always @(negedge clk) begin : mon1
      exp_t e;
      if (c_done === 1'b1) begin
         if (q1.size() == 0) begin
            chk("corner unexpected sw_done", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            chk("corner done cycle", cyc, e.cyc);
            chk("corner done sel", {31'd0, c_sel}, {31'd0, e.sel});
            chk("corner done gate", {31'd0, c_gate}, 32'd1);
         end
      end
   end

   // Invariant: a select change outside reset happens only with the gate
   // off both before and after that edge.
   logic p_sel = 1'bx, p_gate = 1'bx, p_rst = 1'b0;
   logic pc_sel = 1'bx, pc_gate = 1'bx;
   always @(posedge clk) begin
      if (p_rst === 1'b1 && sel !== p_sel)
         chk("dut0 select moved while gated", {30'd0, p_gate, gate}, 32'd0);
      if (p_rst === 1'b1 && c_sel !== pc_sel)
         chk("corner select moved while gated", {30'd0, pc_gate, c_gate}, 32'd0);
      p_sel   <= sel;
      p_gate  <= gate;
      pc_sel  <= c_sel;
      pc_gate <= c_gate;
      p_rst   <= rst_b;
   end

   initial begin
      int e0;
      rst_b = 1'b0; req = 1'b1; tgt = 1'b1; c_req = 1'b1; c_tgt = 1'b1;

      // Reset held 3 edges with a pending request.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset sel", {31'd0, sel}, 32'd0);
         chk("reset gate", {31'd0, gate}, 32'd1);
         chk("reset busy", {31'd0, busy}, 32'd0);
         chk("reset done", {31'd0, done}, 32'd0);
         chk("reset corner sel/gate", {30'd0, c_sel, c_gate}, 32'd1);
      end
      req = 1'b0; c_req = 1'b0; rst_b = 1'b1;
      @(negedge clk);

      // Single switch 0->1.
      issue(0, 1'b1, 12, 1'b1, e0);
      chk("sw gate off after E0", {31'd0, gate}, 32'd0);
      chk("sw busy after E0", {31'd0, busy}, 32'd1);
      wait_to(e0 + 3);
      chk("sw sel before E0+4", {31'd0, sel}, 32'd0);
      wait_to(e0 + 4);
      chk("sw sel after E0+4", {31'd0, sel}, 32'd1);
      chk("sw gate after E0+4", {31'd0, gate}, 32'd0);
      wait_to(e0 + 11);
      chk("sw gate at E0+11", {31'd0, gate}, 32'd0);
      chk("sw done at E0+11", {31'd0, done}, 32'd0);
      wait_to(e0 + 12);
      chk("sw gate at E0+12", {31'd0, gate}, 32'd1);
      wait_to(e0 + 13);
      chk("sw done cleared", {31'd0, done}, 32'd0);

      // No-op request while already on D1.
      issue(0, 1'b1, 0, 1'b1, e0);
      chk("noop done", {31'd0, done}, 32'd1);
      chk("noop gate", {31'd0, gate}, 32'd1);
      chk("noop busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("noop done cleared", {31'd0, done}, 32'd0);

      // Switch back 1->0, then a 0->1 switch with a stray request mid-way.
      issue(0, 1'b0, 12, 1'b1, e0);
      wait_to(e0 + 13);
      chk("back to D0", {31'd0, sel}, 32'd0);
      issue(0, 1'b1, 12, 1'b1, e0);
      wait_to(e0 + 2);
      req = 1'b1; tgt = 1'b0;
      @(negedge clk);
      req = 1'b0;
      wait_to(e0 + 16);
      chk("ignore busy final sel", {31'd0, sel}, 32'd1);
      chk("ignore busy single done", q0.size(), 32'd0);

      // Reset mid-sequence.
      rst_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      chk("reset to D0", {31'd0, sel}, 32'd0);
      @(negedge clk);
      issue(0, 1'b1, 12, 1'b0, e0);
      wait_to(e0 + 5);
      chk("mid sel already moved", {31'd0, sel}, 32'd1);
      rst_b = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      chk("mid reset gate", {31'd0, gate}, 32'd1);
      chk("mid reset sel", {31'd0, sel}, 32'd0);
      chk("mid reset busy", {31'd0, busy}, 32'd0);
      wait_to(e0 + 20);
      chk("mid reset no done", {31'd0, done}, 32'd0);
      issue(0, 1'b1, 12, 1'b1, e0);
      wait_to(e0 + 13);
      chk("fresh after reset sel", {31'd0, sel}, 32'd1);

      // Parameter corner 1/1/1: 0->1 then 1->0.
      issue(1, 1'b1, 2, 1'b1, e0);
      wait_to(e0 + 3);
      issue(1, 1'b0, 2, 1'b1, e0);
      chk("corner gate off E0", {31'd0, c_gate}, 32'd0);
      chk("corner sel E0", {31'd0, c_sel}, 32'd1);
      @(negedge clk);
      chk("corner sel E0+1", {31'd0, c_sel}, 32'd0);
      chk("corner gate E0+1", {31'd0, c_gate}, 32'd0);
      @(negedge clk);
      chk("corner gate E0+2", {31'd0, c_gate}, 32'd1);
      chk("corner done E0+2", {31'd0, c_done}, 32'd1);
      @(negedge clk);
      chk("corner done cleared", {31'd0, c_done}, 32'd0);

      // Drain: every queued completion must have been seen within budget.
      for (int i = 0; i < 30; i++) begin
         if (q0.size() != 0 || q1.size() != 0) @(negedge clk);
      end
      chk("dut0 queue drained", q0.size(), 32'd0);
      chk("corner queue drained", q1.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
